// File: rtl/sfp_pkg.sv
// Shared types and sizing helpers for the multi-core SFP sum exchange.
package sfp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_e;

  localparam int N_CORE_DEFAULT = 4;
  localparam int BW_SUM_DEFAULT = 24;

  // Enough headroom that n sums of bw bits never wrap.
  function automatic int acc_width(input int bw, input int n);
    return bw + $clog2(n);
  endfunction

endpackage

// File: rtl/sfp_prio_enc.sv
// Lowest-set-bit one-hot priority encoder.
module sfp_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         found_o
);

  always_comb begin
    gnt_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !found_o) begin
        gnt_o[i] = 1'b1;
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sfp_sum_exchange.sv
// Collects per-core SFP partial sums, saturates the total and
// broadcasts it back until every participating core acknowledges.
module sfp_sum_exchange
  import sfp_pkg::*;
#(
  parameter int n_core = N_CORE_DEFAULT,
  parameter int bw_sum = BW_SUM_DEFAULT,
  parameter int bw_acc = acc_width(bw_sum, n_core)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [n_core-1:0]        mask,
  input  logic [n_core*bw_sum-1:0] sum_in,
  input  logic [n_core-1:0]        sum_valid,
  output logic [n_core-1:0]        sum_ack,
  output logic [bw_sum-1:0]        sum_out,
  output logic                     sum_out_valid,
  input  logic [n_core-1:0]        out_ack,
  output logic                     busy,
  output logic                     ovf
);

  state_e state_q, state_d;

  logic [bw_acc-1:0] acc_q, acc_d;
  logic [n_core-1:0] cap_q, cap_d;
  logic [n_core-1:0] ackd_q, ackd_d;
  logic [n_core-1:0] mask_q, mask_d;
  logic [bw_sum-1:0] out_q, out_d;
  logic              outv_q, outv_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;

  logic [n_core-1:0] req, gnt;
  logic              found;
  logic [bw_sum-1:0] gsum;
  logic              sat;

  // Held in reset, no core may see a grant.
  always_comb begin
    req = '0;
    if (reset) begin
      unique case (state_q)
        IDLE:    req = sum_valid & mask;
        COLLECT: req = sum_valid & mask_q & ~cap_q;
        default: req = '0;
      endcase
    end
  end

  sfp_prio_enc #(
    .N (n_core)
  ) u_enc (
    .req_i   (req),
    .gnt_o   (gnt),
    .found_o (found)
  );

  always_comb begin
    gsum = '0;
    for (int i = 0; i < n_core; i++) begin
      if (gnt[i]) gsum = gsum | sum_in[i*bw_sum +: bw_sum];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cap_d   = cap_q;
    ackd_d  = ackd_q;
    mask_d  = mask_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    sat     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          mask_d  = mask;
          acc_d   = bw_acc'(gsum);
          cap_d   = gnt;
          ovf_d   = 1'b0;
          state_d = ($countones(mask) == 1) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (found) begin
          acc_d = acc_q + bw_acc'(gsum);
          cap_d = cap_q | gnt;
          if ((cap_q | gnt) == mask_q) state_d = DONE;
        end
      end
      DONE: begin
        ackd_d = ackd_q | (out_ack & mask_q);
        if (ackd_d == mask_q) begin
          ackd_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The broadcast value is frozen on entry to DONE.
    if (state_q != DONE && state_d == DONE) begin
      sat   = |acc_d[bw_acc-1:bw_sum];
      out_d = sat ? '1 : acc_d[bw_sum-1:0];
      ovf_d = sat;
    end
    busy_d = (state_d != IDLE);
    outv_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cap_q   <= '0;
      ackd_q  <= '0;
      mask_q  <= '0;
      out_q   <= '0;
      outv_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cap_q   <= cap_d;
      ackd_q  <= ackd_d;
      mask_q  <= mask_d;
      out_q   <= out_d;
      outv_q  <= outv_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum_ack       = gnt;
  assign sum_out       = out_q;
  assign sum_out_valid = outv_q;
  assign busy          = busy_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_sfp_sum_exchange.sv
// Directed bench for sfp_sum_exchange: table of full rounds plus
// hand-written reset, stall and staggered-acknowledge sequences.
module tb_sfp_sum_exchange;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    mask;
  logic [95:0]   sum_in;
  logic [3:0]    sum_valid;
  logic [3:0]    sum_ack;
  logic [23:0]   sum_out;
  logic          sum_out_valid;
  logic [3:0]    out_ack;
  logic          busy;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]        mask;
    logic [3:0]        valid;
    logic [3:0][23:0]  s;
    int                k;
    logic [15:0]       acks;
    logic [23:0]       exp_sum;
    logic              exp_ovf;
  } vec_t;

  vec_t tbl[6];
  vec_t rst_vec;

  always #5 clk = ~clk;

  sfp_sum_exchange #(
    .n_core (4),
    .bw_sum (24)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mask          (mask),
    .sum_in        (sum_in),
    .sum_valid     (sum_valid),
    .sum_ack       (sum_ack),
    .sum_out       (sum_out),
    .sum_out_valid (sum_out_valid),
    .out_ack       (out_ack),
    .busy          (busy),
    .ovf           (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_round(input vec_t v);
    logic [3:0] vld;
    vld       = v.valid;
    mask      = v.mask;
    sum_in    = v.s;
    sum_valid = vld;
    out_ack   = '0;
    for (int c = 0; c < v.k; c++) begin
      #2;
      chk("ack", 32'(sum_ack), 32'(v.acks[c*4 +: 4]));
      chk("outv_collect", 32'(sum_out_valid), 32'd0);
      if (c == 1) begin
        chk("ovf_start", 32'(ovf), 32'd0);
        chk("busy_collect", 32'(busy), 32'd1);
      end
      step();
      vld       = vld & ~v.acks[c*4 +: 4];
      sum_valid = vld;
    end
    #2;
    chk("outv_done", 32'(sum_out_valid), 32'd1);
    chk("sum_out", 32'(sum_out), 32'(v.exp_sum));
    chk("ovf", 32'(ovf), 32'(v.exp_ovf));
    chk("busy_done", 32'(busy), 32'd1);
    chk("ack_done", 32'(sum_ack), 32'd0);
    out_ack   = v.mask;
    sum_valid = '0;
    step();
    out_ack = '0;
    #2;
    chk("outv_idle", 32'(sum_out_valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("sum_out_hold", 32'(sum_out), 32'(v.exp_sum));
    step();
  endtask

  initial begin
    tbl[0] = '{mask: 4'b1111, valid: 4'b1111,
               s: {24'd40, 24'd30, 24'd20, 24'd10}, k: 4,
               acks: {4'b1000, 4'b0100, 4'b0010, 4'b0001},
               exp_sum: 24'd100, exp_ovf: 1'b0};
    tbl[1] = '{mask: 4'b0101, valid: 4'b0111,
               s: {24'd0, 24'd7, 24'd999, 24'd5}, k: 2,
               acks: {8'h00, 4'b0100, 4'b0001},
               exp_sum: 24'd12, exp_ovf: 1'b0};
    tbl[2] = '{mask: 4'b1111, valid: 4'b1111,
               s: {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}, k: 4,
               acks: {4'b1000, 4'b0100, 4'b0010, 4'b0001},
               exp_sum: 24'hFFFFFF, exp_ovf: 1'b1};
    tbl[3] = '{mask: 4'b1111, valid: 4'b1111,
               s: {24'd1, 24'd1, 24'd1, 24'd1}, k: 4,
               acks: {4'b1000, 4'b0100, 4'b0010, 4'b0001},
               exp_sum: 24'd4, exp_ovf: 1'b0};
    tbl[4] = '{mask: 4'b0100, valid: 4'b0100,
               s: {24'd0, 24'd9, 24'd0, 24'd0}, k: 1,
               acks: {12'h000, 4'b0100},
               exp_sum: 24'd9, exp_ovf: 1'b0};
    tbl[5] = '{mask: 4'b1010, valid: 4'b1010,
               s: {24'd1, 24'd0, 24'hFFFFFF, 24'd0}, k: 2,
               acks: {8'h00, 4'b1000, 4'b0010},
               exp_sum: 24'hFFFFFF, exp_ovf: 1'b1};
    rst_vec = '{mask: 4'b0011, valid: 4'b0011,
                s: {24'd0, 24'd0, 24'd4, 24'd3}, k: 2,
                acks: {8'h00, 4'b0010, 4'b0001},
                exp_sum: 24'd7, exp_ovf: 1'b0};

    reset     = 1'b0;
    mask      = '0;
    sum_in    = '0;
    sum_valid = '0;
    out_ack   = '0;
    step();
    step();
    chk("rst_ack", 32'(sum_ack), 32'd0);
    chk("rst_out", 32'(sum_out), 32'd0);
    chk("rst_outv", 32'(sum_out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) run_round(tbl[i]);

    // Staggered: core3 late by five stall cycles, acks in order 0,2,1,3.
    mask      = 4'b1111;
    sum_in    = {24'd4, 24'd3, 24'd2, 24'd1};
    sum_valid = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("stg_ack", 32'(sum_ack), 32'(1 << c));
      step();
      sum_valid = sum_valid & ~4'(1 << c);
    end
    for (int c = 0; c < 5; c++) begin
      #2;
      chk("stg_stall_ack", 32'(sum_ack), 32'd0);
      chk("stg_stall_busy", 32'(busy), 32'd1);
      chk("stg_stall_outv", 32'(sum_out_valid), 32'd0);
      step();
    end
    sum_valid = 4'b1000;
    #2;
    chk("stg_late_ack", 32'(sum_ack), 32'b1000);
    step();
    sum_valid = '0;
    begin
      int ord[4];
      ord = '{0, 2, 1, 3};
      for (int j = 0; j < 4; j++) begin
        out_ack = 4'(1 << ord[j]);
        if (j == 1) begin
          sum_valid    = 4'b0001;
          sum_in[23:0] = 24'd50;
        end
        #2;
        chk("stg_outv", 32'(sum_out_valid), 32'd1);
        chk("stg_sum", 32'(sum_out), 32'd10);
        chk("stg_done_ack", 32'(sum_ack), 32'd0);
        step();
      end
    end
    out_ack = '0;
    mask    = 4'b0001;
    #2;
    chk("stg_drop", 32'(sum_out_valid), 32'd0);
    chk("stg_idle_busy", 32'(busy), 32'd0);
    chk("stg_new_ack", 32'(sum_ack), 32'b0001);
    step();
    sum_valid = '0;
    out_ack   = 4'b0001;
    #2;
    chk("stg_new_outv", 32'(sum_out_valid), 32'd1);
    chk("stg_new_sum", 32'(sum_out), 32'd50);
    step();
    out_ack = '0;
    #2;
    chk("stg_new_drop", 32'(sum_out_valid), 32'd0);
    step();

    // Reset in COLLECT after two captures.
    mask      = 4'b1111;
    sum_in    = {24'd400, 24'd300, 24'd200, 24'd100};
    sum_valid = 4'b1111;
    #2;
    chk("mr_ack0", 32'(sum_ack), 32'b0001);
    step();
    sum_valid = 4'b1110;
    #2;
    chk("mr_ack1", 32'(sum_ack), 32'b0010);
    step();
    sum_valid = 4'b1100;
    reset     = 1'b0;
    #1;
    chk("mr_ack", 32'(sum_ack), 32'd0);
    chk("mr_out", 32'(sum_out), 32'd0);
    chk("mr_outv", 32'(sum_out_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ovf", 32'(ovf), 32'd0);
    sum_valid = '0;
    step();
    reset = 1'b1;
    step();
    run_round(rst_vec);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
